// File: rtl/locked_reg_pkg.sv
// locked_reg_pkg: shared defaults and debug window state encoding
package locked_reg_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {CLOSED, ARMED, OPEN} dbg_state_e;
endpackage

// File: rtl/locked_register_bank_if.sv
// locked_register_bank_if: write/lock/read/debug bus of the locked register bank
interface locked_register_bank_if
  import locked_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int AW = $clog2(DEPTH);
  logic             write;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] Data_in;
  logic             Lock;
  logic             lock_all;
  logic             trusted;
  logic             debug_mode;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] Data_out;
  logic [DEPTH-1:0] lock_status;
  logic             dbg_open;
  logic             violation;
  logic [CNT_W-1:0] violation_count;
  modport master (
    output write, addr, Data_in, Lock, lock_all, trusted, debug_mode, rd_addr,
    input  Data_out, lock_status, dbg_open, violation, violation_count
  );
  modport slave (
    input  write, addr, Data_in, Lock, lock_all, trusted, debug_mode, rd_addr,
    output Data_out, lock_status, dbg_open, violation, violation_count
  );
endinterface

// File: rtl/locked_register_bank_fsm.sv
// debug_window_fsm: opens the debug window after two consecutive trusted debug requests
module debug_window_fsm
  import locked_reg_pkg::*;
(
  input  logic Clk,
  input  logic reset,
  input  logic debug_mode,
  input  logic trusted,
  output logic dbg_open
);
  dbg_state_e state_q, state_d;
  logic req;
  always_comb begin
    req      = debug_mode & trusted;
    state_d  = !req ? CLOSED : (state_q == CLOSED ? ARMED : OPEN);
    dbg_open = state_q == OPEN;
  end
  always_ff @(posedge Clk or posedge reset)
    if (reset) state_q <= CLOSED;
    else       state_q <= state_d;
endmodule

// File: rtl/locked_register_bank.sv
// locked_register_bank: register array with sticky per-register locks, trusted debug override
// and a saturating count of blocked writes
module locked_register_bank
  import locked_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                  Clk,
  input logic                  reset,
  locked_register_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] lock_q, lock_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             viol_q, viol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbg_open, override, blocked;
  logic [AW-1:0]    waddr;
  debug_window_fsm u_fsm (
    .Clk        (Clk),
    .reset      (reset),
    .debug_mode (bus.debug_mode),
    .trusted    (bus.trusted),
    .dbg_open   (dbg_open)
  );
  // Lock is applied from the current lock vector, so a same-cycle write+Lock still stores
  always_comb begin
    waddr          = bus.addr;
    override       = dbg_open & bus.trusted;
    blocked        = bus.write & lock_q[waddr] & ~override;
    mem_d          = mem_q;
    if (bus.write && !blocked) mem_d[waddr] = bus.Data_in;
    lock_d         = lock_q | (bus.lock_all ? {DEPTH{1'b1}} : (DEPTH'(bus.Lock) << waddr));
    rd_d           = mem_q[bus.rd_addr];
    viol_d         = blocked;
    cnt_d          = (blocked && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      mem_q  <= '{default: '0};
      lock_q <= '0;
      rd_q   <= '0;
      viol_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      lock_q <= lock_d;
      rd_q   <= rd_d;
      viol_q <= viol_d;
      cnt_q  <= cnt_d;
    end
  assign bus.Data_out        = rd_q;
  assign bus.lock_status     = lock_q;
  assign bus.dbg_open        = dbg_open;
  assign bus.violation       = viol_q;
  assign bus.violation_count = cnt_q;
endmodule

// File: tb/tb_locked_register_bank.sv
// tb_locked_register_bank: directed checks of locking, debug override, reset and counter saturation
module tb_locked_register_bank;
  logic Clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 Clk = ~Clk;
  locked_register_bank_if #(.WIDTH(16), .DEPTH(8), .CNT_W(8)) b ();
  locked_register_bank_if #(.WIDTH(16), .DEPTH(8), .CNT_W(4)) s ();
  locked_register_bank #(.WIDTH(16), .DEPTH(8), .CNT_W(8)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (b.slave)
  );
  locked_register_bank #(.WIDTH(16), .DEPTH(8), .CNT_W(4)) dut_sat (
    .Clk   (Clk),
    .reset (reset),
    .bus   (s.slave)
  );
  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    {b.write, b.addr, b.Data_in, b.Lock, b.lock_all, b.trusted, b.debug_mode, b.rd_addr} = '0;
    {s.write, s.addr, s.Data_in, s.Lock, s.lock_all, s.trusted, s.debug_mode, s.rd_addr} = '0;
    reset = 1'b1;
    #2;
    chk("rst_dout", 32'(b.Data_out), 32'h0);
    chk("rst_lock", 32'(b.lock_status), 32'h0);
    chk("rst_dbg", 32'(b.dbg_open), 32'h0);
    chk("rst_viol", 32'(b.violation), 32'h0);
    chk("rst_cnt", 32'(b.violation_count), 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
    // reset scenario
    b.write = 1'b1; b.addr = 3'd3; b.Data_in = 16'h1234;
    cycle();
    b.write = 1'b0; b.Lock = 1'b1;
    cycle();
    b.Lock = 1'b0; b.rd_addr = 3'd3;
    cycle();
    chk("r3_before_rst", 32'(b.Data_out), 32'h1234);
    chk("lock3_before_rst", 32'(b.lock_status), 32'h08);
    reset = 1'b1;
    #1;
    chk("async_rst_dout", 32'(b.Data_out), 32'h0);
    chk("async_rst_lock", 32'(b.lock_status), 32'h0);
    cycle();
    reset = 1'b0;
    cycle();
    chk("r3_after_rst", 32'(b.Data_out), 32'h0);
    // lock scenario
    b.write = 1'b1; b.addr = 3'd2; b.Data_in = 16'hAAAA;
    cycle();
    b.write = 1'b0; b.Lock = 1'b1;
    cycle();
    b.Lock = 1'b0; b.write = 1'b1; b.Data_in = 16'h5555;
    cycle();
    chk("blocked_viol", 32'(b.violation), 32'h1);
    chk("blocked_cnt1", 32'(b.violation_count), 32'h1);
    b.write = 1'b0; b.rd_addr = 3'd2;
    cycle();
    chk("viol_one_cycle", 32'(b.violation), 32'h0);
    chk("r2_kept", 32'(b.Data_out), 32'hAAAA);
    chk("cnt_hold", 32'(b.violation_count), 32'h1);
    // debug window scenario
    b.debug_mode = 1'b1; b.trusted = 1'b1;
    cycle();
    chk("armed_not_open", 32'(b.dbg_open), 32'h0);
    cycle();
    chk("dbg_open", 32'(b.dbg_open), 32'h1);
    b.write = 1'b1; b.addr = 3'd2; b.Data_in = 16'hBEEF;
    cycle();
    chk("override_no_viol", 32'(b.violation), 32'h0);
    b.write = 1'b0; b.trusted = 1'b0;
    cycle();
    chk("dbg_closed", 32'(b.dbg_open), 32'h0);
    chk("r2_beef", 32'(b.Data_out), 32'hBEEF);
    b.write = 1'b1; b.Data_in = 16'h1111;
    cycle();
    chk("post_dbg_viol", 32'(b.violation), 32'h1);
    chk("post_dbg_cnt", 32'(b.violation_count), 32'h2);
    b.write = 1'b0; b.debug_mode = 1'b0;
    cycle();
    chk("r2_still_beef", 32'(b.Data_out), 32'hBEEF);
    // short debug request
    b.debug_mode = 1'b1; b.trusted = 1'b1;
    cycle();
    b.debug_mode = 1'b0; b.write = 1'b1; b.Data_in = 16'h2222;
    cycle();
    chk("short_dbg_closed", 32'(b.dbg_open), 32'h0);
    chk("short_dbg_viol", 32'(b.violation), 32'h1);
    chk("short_dbg_cnt", 32'(b.violation_count), 32'h3);
    b.write = 1'b0; b.trusted = 1'b0;
    cycle();
    chk("short_r2", 32'(b.Data_out), 32'hBEEF);
    // simultaneous write+lock and read-during-write
    b.write = 1'b1; b.Lock = 1'b1; b.addr = 3'd5; b.Data_in = 16'h0F0F; b.rd_addr = 3'd5;
    cycle();
    chk("rdw_old", 32'(b.Data_out), 32'h0);
    chk("lock_2_5", 32'(b.lock_status), 32'h24);
    chk("wl_no_viol", 32'(b.violation), 32'h0);
    b.write = 1'b0; b.Lock = 1'b0;
    cycle();
    chk("r5_0f0f", 32'(b.Data_out), 32'h0F0F);
    b.write = 1'b1; b.Data_in = 16'hFFFF;
    cycle();
    chk("r5_locked_viol", 32'(b.violation), 32'h1);
    chk("r5_locked_cnt", 32'(b.violation_count), 32'h4);
    b.write = 1'b0; b.lock_all = 1'b1;
    cycle();
    b.lock_all = 1'b0;
    chk("lock_all", 32'(b.lock_status), 32'hFF);
    chk("r5_unchanged", 32'(b.Data_out), 32'h0F0F);
    // reset mid debug session
    b.debug_mode = 1'b1; b.trusted = 1'b1;
    cycle();
    cycle();
    chk("dbg_open2", 32'(b.dbg_open), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_closes_dbg", 32'(b.dbg_open), 32'h0);
    chk("rst_clears_cnt", 32'(b.violation_count), 32'h0);
    cycle();
    reset = 1'b0; b.debug_mode = 1'b0; b.trusted = 1'b0;
    // saturation with a 4-bit counter
    s.Lock = 1'b1; s.addr = 3'd0;
    cycle();
    s.Lock = 1'b0; s.write = 1'b1; s.Data_in = 16'h0009;
    repeat (3) cycle();
    chk("sat_cnt3", 32'(s.violation_count), 32'h3);
    repeat (17) cycle();
    chk("sat_cnt15", 32'(s.violation_count), 32'hF);
    chk("sat_viol", 32'(s.violation), 32'h1);
    s.write = 1'b0;
    cycle();
    cycle();
    chk("sat_hold", 32'(s.violation_count), 32'hF);
    chk("sat_r0", 32'(s.Data_out), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/locked_register_bank.md
LOCKED_REGISTER_BANK -- requirements
Module: locked_register_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data width of each register.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of registers (power of two, 2..64).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of the violation counter.
REQ-004 The block SHALL have derived localparam AW = clog2(DEPTH), used as the address width.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port write, input, 1 bit: write request for the register at addr.
REQ-008 The block SHALL have port addr, input, AW bits: write and lock target index.
REQ-009 The block SHALL have port Data_in, input, WIDTH bits: write data.
REQ-010 The block SHALL have port Lock, input, 1 bit: sets the sticky lock bit of register addr.
REQ-011 The block SHALL have port lock_all, input, 1 bit: sets every lock bit.
REQ-012 The block SHALL have port trusted, input, 1 bit: trusted-agent qualifier for debug override.
REQ-013 The block SHALL have port debug_mode, input, 1 bit: debug override request.
REQ-014 The block SHALL have port rd_addr, input, AW bits: read index.
REQ-015 The block SHALL have port Data_out, output, WIDTH bits: registered read data of register rd_addr.
REQ-016 The block SHALL have port lock_status, output, DEPTH bits: current lock bits.
REQ-017 The block SHALL have port dbg_open, output, 1 bit: the debug window FSM is in OPEN.
REQ-018 The block SHALL have port violation, output, 1 bit: one-cycle pulse on each blocked write.
REQ-019 The block SHALL have port violation_count, output, CNT_W bits: saturating count of blocked writes.

Function
REQ-020 Lock bits SHALL be sticky, settable only (Lock sets bit addr; lock_all sets all bits), and cleared only by reset.
REQ-021 Lock and write in the same cycle to the same addr SHALL write first: the data is stored and the lock takes effect from the next cycle.
REQ-022 A write to an unlocked register SHALL store Data_in at the next edge.
REQ-023 A write to a locked register SHALL be stored only when dbg_open=1 and trusted=1 in that cycle.
REQ-024 The debug window FSM SHALL have states CLOSED, ARMED and OPEN.
REQ-025 The FSM SHALL move CLOSED->ARMED when debug_mode&trusted is 1.
REQ-026 The FSM SHALL move ARMED->OPEN when debug_mode&trusted remains 1 for a second consecutive cycle, and ARMED->CLOSED otherwise.
REQ-027 The FSM SHALL move OPEN->CLOSED on the first cycle in which debug_mode&trusted is 0.
REQ-028 A locked write attempted while the FSM is in CLOSED or ARMED SHALL be blocked.
REQ-029 A blocked write SHALL leave the register unchanged, assert violation for exactly one cycle (registered, one cycle after the attempt), and increment violation_count.
REQ-030 violation_count SHALL saturate at all-ones and never wrap.
REQ-031 Data_out SHALL equal the register at rd_addr as sampled one cycle earlier (1-cycle read latency).
REQ-032 A read and a write to the same index in the same cycle SHALL return the old value.
REQ-033 An addr or rd_addr of DEPTH or greater cannot occur, because DEPTH is a power of two.

Reset
REQ-034 While reset=1, all registers SHALL be 0, Data_out SHALL be 0, lock_status SHALL be 0, the FSM SHALL be in CLOSED, violation SHALL be 0 and violation_count SHALL be 0, asynchronously.
REQ-035 Reset asserted mid debug session SHALL close the window immediately.
REQ-036 The first cycle after reset deassertion SHALL be treated as a normal cycle.

Structure
REQ-037 The FSM state enumeration (CLOSED, ARMED, OPEN) SHALL be defined in the shared package locked_reg_pkg.
REQ-038 The package SHALL also hold the default WIDTH, DEPTH and CNT_W constants.
REQ-039 The debug window FSM SHALL be a sub-module named debug_window_fsm, with inputs Clk, reset, debug_mode and trusted and output dbg_open.
REQ-040 The register array, lock vector and violation logic SHALL reside in locked_register_bank.

Verification
REQ-041 Reset scenario: write 0x1234 to reg 3, lock reg 3, then pulse reset -> reg 3 reads 0x0000 and lock_status reads 0x00.
REQ-042 Lock scenario: write 0xAAAA to reg 2, Lock reg 2, then write 0x5555 -> reg 2 reads 0xAAAA, violation pulses once and violation_count=1.
REQ-043 Debug window scenario: hold debug_mode=trusted=1 for 2 cycles -> dbg_open=1; a write of 0xBEEF to locked reg 2 succeeds; drop trusted -> dbg_open=0 in the next cycle and the following write is blocked.
REQ-044 Short debug scenario: debug_mode&trusted held for only 1 cycle -> dbg_open stays 0 and a locked write is blocked.
REQ-045 Simultaneous scenario: write 0x0F0F with Lock on reg 5 in one cycle -> reg 5 reads 0x0F0F and lock_status[5]=1; lock_all -> all lock bits 1.
REQ-046 Saturation scenario: with CNT_W=4, perform 20 blocked writes -> violation_count=15 and holds at 15.
